overlap_framer: RTL and testbench
=================================

OVERLAP_FRAMER -- requirements
Module: overlap_framer

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16: sample width in bits.
REQ-002 SHALL have parameter FRAME_SIZE, default 256: samples per emitted frame.
REQ-003 SHALL have parameter HOP_SIZE, default 128: frame start spacing, legal 1..FRAME_SIZE.
REQ-004 SHALL have parameter BUF_DEPTH, default 512: circular buffer depth, power of 2, at least 2*FRAME_SIZE.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port enable, input, 1 bit: run; low forces IDLE.
REQ-008 SHALL have port flush, input, 1 bit: single-cycle pulse requesting zero-padded final frame.
REQ-009 SHALL have port sample_in, input, SAMPLE_WIDTH bits: audio sample.
REQ-010 SHALL have port sample_valid, input, 1 bit: sample_in qualifier, no backpressure.
REQ-011 SHALL have port out_sample, output, SAMPLE_WIDTH bits: frame sample.
REQ-012 SHALL have port out_valid, output, 1 bit: out_sample qualifier.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-014 SHALL have port out_last, output, 1 bit: final sample of a frame.
REQ-015 SHALL have port frame_count, output, 16 bits: completed frames, wraps.
REQ-016 SHALL have port overflow, output, 1 bit: sticky; a sample was dropped.
REQ-017 SHALL have port busy, output, 1 bit: state not IDLE.

Function
REQ-018 SHALL implement states IDLE, FILL, EMIT, PAD.
- IDLE -> FILL when enable=1.
- FILL -> EMIT when fill >= FRAME_SIZE.
- FILL -> PAD when flush=1 and 0 < fill < FRAME_SIZE.
- EMIT/PAD -> FILL on the out_last handshake.
- PAD -> IDLE when that frame was a flush frame.
REQ-019 SHALL write an accepted sample to buffer[wr_ptr] and increment wr_ptr modulo BUF_DEPTH in every non-IDLE state.
REQ-020 SHALL keep fill = samples written minus base pointer; a simultaneous write and base advance SHALL yield fill+1-HOP_SIZE in the same cycle.
REQ-021 SHALL drop sample_valid when fill == BUF_DEPTH, with no advance, and SHALL set overflow; overflow clears only in IDLE.
REQ-022 SHALL emit frame samples base, base+1, ..., base+FRAME_SIZE-1 (mod BUF_DEPTH) in order, one per out_valid&&out_ready handshake.
REQ-023 SHALL assert first out_valid one cycle after the edge on which fill reaches FRAME_SIZE.
REQ-024 SHALL hold out_sample, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL sustain one sample per cycle with out_ready held high, and SHALL emit no gap cycle between back-to-back frames when the next frame is already complete.
REQ-026 SHALL, on the out_last handshake, advance base by HOP_SIZE, reduce fill by HOP_SIZE, and increment frame_count (wrapping 0xFFFF->0).
REQ-027 SHALL, in PAD, emit the fill remaining samples followed by FRAME_SIZE-fill zeros, then clear pointers and fill.
REQ-028 SHALL ignore flush in EMIT, and in FILL when fill = 0 or fill >= FRAME_SIZE.
REQ-029 SHALL, when enable is deasserted, enter IDLE on the next edge, drop out_valid, clear wr_ptr, base and fill, and discard any partial frame, with frame_count retained.
REQ-030 SHALL drive busy = (state != IDLE).

Reset
REQ-031 SHALL, on rst_n low, asynchronously set state IDLE, all pointers and fill 0, out_valid 0, out_last 0, out_sample 0, frame_count 0, overflow 0, busy 0.
REQ-032 SHALL release reset synchronously, with the first state change on the edge after rst_n rises.

Verification (FRAME_SIZE=8, HOP_SIZE=4, BUF_DEPTH=16)
REQ-033 SHALL cover: samples 1..16 continuous, out_ready=1 -> frames [1..8], [5..12], [9..16]; frame_count=3; out_last on 8, 12, 16.
REQ-034 SHALL cover: 8th sample written at edge E -> out_valid high after E+1; out_ready toggled 0/1 -> each sample held stable until accepted.
REQ-035 SHALL cover: out_ready=0 while 17 samples are fed -> overflow=1 after the 17th, and sample 17 never appears in any output.
REQ-036 SHALL cover: samples 1..3 then flush pulse -> frame 1,2,3,0,0,0,0,0 with out_last on the final 0; then state IDLE, busy=0.
REQ-037 SHALL cover: enable dropped mid-EMIT -> out_valid=0 next cycle; after re-enable and 8 new samples, the frame holds only the new samples.
REQ-038 SHALL cover: rst_n asserted mid-frame between edges -> all outputs reach reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/overlap_framer.sv
`default_nettype none
// ============================================================================
//  Module   : overlap_framer
//  Purpose  : Circular-buffer framer emitting overlapping, hop-spaced frames
//             with flush-driven zero padding of a final partial frame.
//  Revision : 1.0  initial release
// ============================================================================
module overlap_framer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAME_SIZE   = 256,
  parameter int HOP_SIZE     = 128,
  parameter int BUF_DEPTH    = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    flush,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic [SAMPLE_WIDTH-1:0] out_sample,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [15:0]             frame_count,
  output logic                    overflow,
  output logic                    busy
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int IW = $clog2(FRAME_SIZE + 1);

  localparam logic [AW:0]   FILL_FULL  = (AW+1)'(BUF_DEPTH);
  localparam logic [AW:0]   FILL_FRAME = (AW+1)'(FRAME_SIZE);
  localparam logic [AW:0]   FILL_HOP   = (AW+1)'(HOP_SIZE);
  localparam logic [AW-1:0] PTR_HOP    = AW'(HOP_SIZE);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(FRAME_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2,
    PAD  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [SAMPLE_WIDTH-1:0] mem [BUF_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           base;
  logic [AW:0]             fill;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           pad_len;

  logic                    hs;
  logic                    wr_en;
  logic                    overrun;
  logic [AW:0]             fill_inc;
  logic [AW:0]             fill_adv;
  logic                    adv;
  logic                    done;
  logic                    clear;
  logic                    load;
  logic                    pad_start;
  logic [IW-1:0]           ld_idx;
  logic                    out_valid_next;
  logic                    out_last_next;
  logic [AW-1:0]           rd_base;
  logic [AW-1:0]           rd_addr;
  logic                    pad_zero;
  logic [SAMPLE_WIDTH-1:0] out_sample_next;

  assign hs       = out_valid && out_ready;
  assign wr_en    = sample_valid && (state != IDLE) && (fill != FILL_FULL);
  assign overrun  = sample_valid && (state != IDLE) && (fill == FILL_FULL);
  assign fill_inc = fill + {{AW{1'b0}}, wr_en};
  assign fill_adv = fill_inc - FILL_HOP;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A frame end stays in EMIT when the following frame is already buffered,
  // so consecutive frames stream without a bubble.
  always_comb begin
    state_next     = state;
    adv            = 1'b0;
    done           = 1'b0;
    clear          = 1'b0;
    load           = 1'b0;
    pad_start      = 1'b0;
    ld_idx         = idx + IDX_ONE;
    out_valid_next = out_valid;
    out_last_next  = out_last;

    case (state)
      IDLE: begin
        if (enable) begin
          state_next = FILL;
        end
      end
      FILL: begin
        if (fill >= FILL_FRAME) begin
          state_next = EMIT;
          load       = 1'b1;
          ld_idx     = '0;
        end else if (flush && (fill != '0)) begin
          state_next = PAD;
          load       = 1'b1;
          ld_idx     = '0;
          pad_start  = 1'b1;
        end
      end
      EMIT: begin
        if (hs) begin
          if (out_last) begin
            done = 1'b1;
            adv  = 1'b1;
            if (fill_adv >= FILL_FRAME) begin
              load   = 1'b1;
              ld_idx = '0;
            end else begin
              state_next     = FILL;
              out_valid_next = 1'b0;
              out_last_next  = 1'b0;
            end
          end else begin
            load = 1'b1;
          end
        end
      end
      PAD: begin
        if (hs) begin
          if (out_last) begin
            done           = 1'b1;
            clear          = 1'b1;
            state_next     = IDLE;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (!enable) begin
      state_next     = IDLE;
      clear          = 1'b1;
      adv            = 1'b0;
      done           = 1'b0;
      load           = 1'b0;
      pad_start      = 1'b0;
      out_valid_next = 1'b0;
      out_last_next  = 1'b0;
    end

    if (load) begin
      out_valid_next = 1'b1;
      out_last_next  = (ld_idx == IDX_LAST);
    end
  end

  // Read address follows the base as it will be after this edge.
  always_comb begin
    rd_base         = adv ? (base + PTR_HOP) : base;
    rd_addr         = rd_base + AW'(ld_idx);
    pad_zero        = (state == PAD) && (ld_idx >= pad_len);
    out_sample_next = pad_zero ? '0 : mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      base        <= '0;
      fill        <= '0;
      idx         <= '0;
      pad_len     <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_sample  <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
    end else begin
      out_valid <= out_valid_next;
      out_last  <= out_last_next;

      if (load) begin
        out_sample <= out_sample_next;
        idx        <= ld_idx;
      end

      if (pad_start) begin
        pad_len <= fill[IW-1:0];
      end

      if (clear) begin
        wr_ptr <= '0;
        base   <= '0;
        fill   <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (adv) begin
          base <= base + PTR_HOP;
          fill <= fill_adv;
        end else begin
          fill <= fill_inc;
        end
      end

      if (done) begin
        frame_count <= frame_count + 16'd1;
      end

      if (state == IDLE) begin
        overflow <= 1'b0;
      end else if (overrun) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_overlap_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_overlap_framer
//  Purpose  : Directed self-checking bench for overlap_framer (8/4/16 setup).
//  Revision : 1.0  initial release
// ============================================================================
module tb_overlap_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        flush;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [15:0] out_sample;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] frame_count;
  logic        overflow;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;
  int exp_q[$];
  bit last_q[$];

  overlap_framer #(
    .SAMPLE_WIDTH(16),
    .FRAME_SIZE  (8),
    .HOP_SIZE    (4),
    .BUF_DEPTH   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .flush       (flush),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .out_sample  (out_sample),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .frame_count (frame_count),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int first, input int nreal);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back((i < nreal) ? (first + i) : 0);
      last_q.push_back(i == 7);
    end
  endtask

  // ready_mode: 0 = held high, 1 = held low, 2 = toggling starting low
  task automatic run_cycles(input int ncyc, input int feed_from, input int feed_cnt,
                            input int ready_mode);
    logic        pv;
    logic        pr;
    logic [15:0] ps;
    logic        pl;
    int          extra;
    pv = 1'b0; pr = 1'b0; ps = '0; pl = 1'b0; extra = 0;
    for (int c = 0; c < ncyc; c++) begin
      sample_valid = (c < feed_cnt);
      sample_in    = (c < feed_cnt) ? 16'(feed_from + c) : 16'd0;
      out_ready    = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : c[0];
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_sample, ps);
        chk("hold_last", out_last, pl);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) begin
          chk("frame_data", out_sample, exp_q.pop_front());
          chk("frame_last", out_last, last_q.pop_front());
        end else begin
          extra++;
        end
      end
      pv = out_valid; pr = out_ready; ps = out_sample; pl = out_last;
      tick();
    end
    sample_valid = 1'b0;
    chk("extra_hs", extra, 0);
  endtask

  task automatic restart();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0;
    sample_in = '0; sample_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_sample", out_sample, 0);
    chk("rst_fcount", frame_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();
    chk("fill_busy", busy, 1);

    // continuous stream, three overlapping frames back to back
    push_frame(1, 8); push_frame(5, 8); push_frame(9, 8);
    run_cycles(40, 1, 16, 0);
    chk("t1_drained", exp_q.size(), 0);
    chk("t1_fcount", frame_count, 3);
    chk("t1_valid", out_valid, 0);
    restart();

    // first-valid latency and stall hold with toggling ready
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample_valid = 1'b1;
      sample_in    = 16'(101 + i);
      tick();
    end
    sample_valid = 1'b0;
    chk("lat_pre", out_valid, 0);
    tick();
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_sample, 101);
    chk("lat_last", out_last, 0);
    push_frame(101, 8);
    run_cycles(24, 0, 0, 2);
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_fcount", frame_count, 4);
    restart();

    // overflow on the 17th sample with the output stalled
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      sample_valid = 1'b1;
      sample_in    = 16'(201 + i);
      tick();
      if (i == 15) chk("ovf_at_full", overflow, 0);
    end
    sample_valid = 1'b0;
    chk("ovf_set", overflow, 1);
    push_frame(201, 8); push_frame(205, 8); push_frame(209, 8);
    run_cycles(40, 0, 0, 0);
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_fcount", frame_count, 7);
    chk("ovf_sticky", overflow, 1);
    enable = 1'b0;
    tick();
    tick();
    chk("ovf_clear", overflow, 0);
    chk("idle_busy", busy, 0);
    enable = 1'b1;
    tick();

    // flush with nothing buffered is ignored
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_empty_valid", out_valid, 0);
    chk("flush_empty_busy", busy, 1);

    // flush after three samples pads the frame with zeros
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample_in    = 16'(301 + i);
      tick();
    end
    sample_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push_frame(301, 3);
    run_cycles(8, 0, 0, 0);
    chk("t4_drained", exp_q.size(), 0);
    chk("pad_busy", busy, 0);
    chk("pad_valid", out_valid, 0);
    chk("pad_fcount", frame_count, 8);
    tick();
    chk("pad_rearm", busy, 1);

    // enable dropped in the middle of a frame
    push_frame(401, 8);
    run_cycles(11, 401, 8, 0);
    chk("mid_valid", out_valid, 1);
    chk("mid_data", out_sample, 403);
    exp_q.delete(); last_q.delete();
    out_ready = 1'b0;
    enable    = 1'b0;
    tick();
    chk("dis_valid", out_valid, 0);
    chk("dis_busy", busy, 0);
    chk("dis_fcount", frame_count, 8);
    enable = 1'b1;
    tick();
    push_frame(501, 8);
    run_cycles(20, 501, 8, 0);
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_fcount", frame_count, 9);
    restart();

    // asynchronous reset between clock edges
    push_frame(601, 8);
    run_cycles(12, 601, 8, 0);
    exp_q.delete(); last_q.delete();
    chk("pre_rst_data", out_sample, 604);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_last", out_last, 0);
    chk("arst_sample", out_sample, 0);
    chk("arst_fcount", frame_count, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
